// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and writeback result selection for the RV32I core.
//   Registers the Memory-stage outputs. From the registered values it then
//   produces the register-file write port (we3/a3/wd3) and the W-stage
//   forwarding value. Load data is extracted and extended in this stage.
//   The stage also keeps a count of retired instructions.
//
// Ports
//   clk, reset_n        clock; synchronous active-low reset
//   stall_w, flush_w    hold / bubble the W stage (flush has priority)
//   valid_m ... rd_m    Memory-stage instruction fields to capture
//   regwrite_w, rd_w    register-file write enable and address
//   result_w            register-file write data and forwarding value
//   valid_w             W stage holds a real instruction
//   instret_w           retired-instruction counter (wraps)
module mem_wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic             regwrite_m,
    input  logic [1:0]       resultsrc_m,
    input  logic [2:0]       funct3_m,
    input  logic [31:0]      aluresult_m,
    input  logic [31:0]      readdata_m,
    input  logic [31:0]      pcplus4_m,
    input  logic [4:0]       rd_m,
    output logic             regwrite_w,
    output logic [4:0]       rd_w,
    output logic [31:0]      result_w,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret_w
);

    logic             valid_q;
    logic             regwrite_q;
    logic [1:0]       resultsrc_q;
    logic [2:0]       funct3_q;
    logic [31:0]      aluresult_q;
    logic [31:0]      readdata_q;
    logic [31:0]      pcplus4_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            funct3_q    <= 3'b000;
            aluresult_q <= 32'h0;
            readdata_q  <= 32'h0;
            pcplus4_q   <= 32'h0;
            rd_q        <= 5'd0;
            instret_q   <= '0;
        end else if (flush_w) begin
            // Bubble: every field is cleared, but the retired count stays put.
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            funct3_q    <= 3'b000;
            aluresult_q <= 32'h0;
            readdata_q  <= 32'h0;
            pcplus4_q   <= 32'h0;
            rd_q        <= 5'd0;
        end else if (!stall_w) begin
            valid_q     <= valid_m;
            regwrite_q  <= regwrite_m;
            resultsrc_q <= resultsrc_m;
            funct3_q    <= funct3_m;
            aluresult_q <= aluresult_m;
            readdata_q  <= readdata_m;
            pcplus4_q   <= pcplus4_m;
            rd_q        <= rd_m;
            if (valid_m) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        load_byte = 8'h0;
        load_half = 16'h0;
        load_data = readdata_q;
        case (aluresult_q[1:0])
            2'd0:    load_byte = readdata_q[7:0];
            2'd1:    load_byte = readdata_q[15:8];
            2'd2:    load_byte = readdata_q[23:16];
            default: load_byte = readdata_q[31:24];
        endcase
        // Halfword select ignores address bit 0; misaligned halves are not split.
        load_half = aluresult_q[1] ? readdata_q[31:16] : readdata_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = readdata_q;   // LW and reserved encodings
        endcase
    end

    always_comb begin
        result_w = 32'h0;
        if (valid_q) begin
            case (resultsrc_q)
                2'b01:   result_w = load_data;
                2'b10:   result_w = pcplus4_q;
                default: result_w = aluresult_q;   // 00 ALU, 11 reserved
            endcase
        end
    end

    // x0 is hardwired to zero, so a write to it is suppressed here.
    assign regwrite_w = regwrite_q & valid_q & (rd_q != 5'd0);
    assign rd_w       = rd_q;
    assign valid_w    = valid_q;
    assign instret_w  = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_w, flush_w, valid_m, regwrite_m;
    logic [1:0]  resultsrc_m;
    logic [2:0]  funct3_m;
    logic [31:0] aluresult_m, readdata_m, pcplus4_m;
    logic [4:0]  rd_m;

    logic        regwrite_w, valid_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [63:0] instret_w;

    logic        regwrite_w2, valid_w2;
    logic [4:0]  rd_w2;
    logic [31:0] result_w2;
    logic [3:0]  instret_w2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
        .funct3_m(funct3_m), .aluresult_m(aluresult_m), .readdata_m(readdata_m),
        .pcplus4_m(pcplus4_m), .rd_m(rd_m),
        .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
        .valid_w(valid_w), .instret_w(instret_w)
    );

    // Narrow counter instance so the wrap can be reached in a few cycles.
    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
        .funct3_m(funct3_m), .aluresult_m(aluresult_m), .readdata_m(readdata_m),
        .pcplus4_m(pcplus4_m), .rd_m(rd_m),
        .regwrite_w(regwrite_w2), .rd_w(rd_w2), .result_w(result_w2),
        .valid_w(valid_w2), .instret_w(instret_w2)
    );

    typedef struct {
        string       name;
        logic        stall, flush, valid, regwrite;
        logic [1:0]  rsrc;
        logic [2:0]  f3;
        logic [31:0] alu, rdata, pc4;
        logic [4:0]  rd;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        logic        e_valid;
        logic [63:0] e_inst;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [31:0] pc4, input logic [4:0] rd);
        stall_w = st; flush_w = fl; valid_m = v; regwrite_m = rw;
        resultsrc_m = rs; funct3_m = f3; aluresult_m = alu;
        readdata_m = rdat; pcplus4_m = pc4; rd_m = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic e_rw, input logic [4:0] e_rd,
                             input logic [31:0] e_res, input logic e_v, input logic [63:0] e_inst);
        check({name, ".regwrite_w"}, 64'(regwrite_w), 64'(e_rw));
        check({name, ".rd_w"},       64'(rd_w),       64'(e_rd));
        check({name, ".result_w"},   64'(result_w),   64'(e_res));
        check({name, ".valid_w"},    64'(valid_w),    64'(e_v));
        check({name, ".instret_w"},  instret_w,       e_inst);
        check({name, ".instret4"},   64'(instret_w2), 64'(e_inst[3:0]));
    endtask

    initial begin
        //            name       st fl v  rw rs     f3      alu           rdata         pc4           rd     e_rw e_rd  e_res         e_v e_inst
        vecs[0]  = '{"lb_neg",   0, 0, 1, 1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0,       5'd5,  1, 5'd5, 32'hFFFF_FF80, 1, 64'd1};
        vecs[1]  = '{"lbu",      0, 0, 1, 1, 2'b01, 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0,       5'd5,  1, 5'd5, 32'h0000_0080, 1, 64'd2};
        vecs[2]  = '{"lh_hi",    0, 0, 1, 1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'h0,       5'd6,  1, 5'd6, 32'hFFFF_8001, 1, 64'd3};
        vecs[3]  = '{"lh_lo",    0, 0, 1, 1, 2'b01, 3'b001, 32'h0000_2000, 32'h8001_7FFF, 32'h0,       5'd6,  1, 5'd6, 32'h0000_7FFF, 1, 64'd4};
        vecs[4]  = '{"lhu_hi",   0, 0, 1, 1, 2'b01, 3'b101, 32'h0000_2003, 32'h8001_7FFF, 32'h0,       5'd6,  1, 5'd6, 32'h0000_8001, 1, 64'd5};
        vecs[5]  = '{"lw",       0, 0, 1, 1, 2'b01, 3'b010, 32'h0000_2001, 32'hDEAD_BEEF, 32'h0,       5'd7,  1, 5'd7, 32'hDEAD_BEEF, 1, 64'd6};
        vecs[6]  = '{"ld_rsvd",  0, 0, 1, 1, 2'b01, 3'b011, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,       5'd7,  1, 5'd7, 32'hDEAD_BEEF, 1, 64'd7};
        vecs[7]  = '{"lb_off1",  0, 0, 1, 1, 2'b01, 3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0,       5'd8,  1, 5'd8, 32'h0000_0012, 1, 64'd8};
        vecs[8]  = '{"alu_x0",   0, 0, 1, 1, 2'b00, 3'b000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0,       5'd0,  0, 5'd0, 32'h1234_5678, 1, 64'd9};
        vecs[9]  = '{"src_rsvd", 0, 0, 1, 1, 2'b11, 3'b000, 32'hCAFE_0000, 32'h1111_1111, 32'h2222_2222, 5'd3, 1, 5'd3, 32'hCAFE_0000, 1, 64'd10};
        vecs[10] = '{"pc4",      0, 0, 1, 1, 2'b10, 3'b000, 32'hCAFE_0000, 32'h1111_1111, 32'h0000_0104, 5'd1, 1, 5'd1, 32'h0000_0104, 1, 64'd11};
        vecs[11] = '{"bubble",   0, 0, 0, 1, 2'b00, 3'b000, 32'h0000_0055, 32'h0,       32'h0,       5'd4,  0, 5'd4, 32'h0,         0, 64'd11};
        vecs[12] = '{"no_rw",    0, 0, 1, 0, 2'b00, 3'b000, 32'h0000_0077, 32'h0,       32'h0,       5'd8,  0, 5'd8, 32'h0000_0077, 1, 64'd12};
        vecs[13] = '{"flush",    0, 1, 1, 1, 2'b00, 3'b000, 32'h0000_0099, 32'h0,       32'h0,       5'd9,  0, 5'd0, 32'h0,         0, 64'd12};

        // Reset with busy, nonzero inputs for two cycles.
        reset_n = 1'b0;
        drive(1, 1, 1, 1, 2'b01, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        tick();
        check_all("reset1", 0, 5'd0, 32'h0, 0, 64'd0);
        drive(0, 0, 1, 1, 2'b10, 3'b001, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_0000, 5'd17);
        tick();
        check_all("reset2", 0, 5'd0, 32'h0, 0, 64'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].regwrite, vecs[i].rsrc,
                  vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc4, vecs[i].rd);
            tick();
            check_all(vecs[i].name, vecs[i].e_rw, vecs[i].e_rd, vecs[i].e_res, vecs[i].e_valid, vecs[i].e_inst);
        end

        // JAL into x1, then three stall cycles with different M-stage contents.
        drive(0, 0, 1, 1, 2'b10, 3'b000, 32'h0000_0800, 32'h0, 32'h0000_0104, 5'd1);
        tick();
        check_all("jal", 1, 5'd1, 32'h0000_0104, 1, 64'd13);
        for (int s = 0; s < 3; s++) begin
            drive(1, 0, 1, 1, 2'b00, 3'b000, 32'h0BAD_0000 + 32'(s), 32'h0, 32'h0, 5'd20);
            tick();
            check_all($sformatf("stall%0d", s), 1, 5'd1, 32'h0000_0104, 1, 64'd13);
        end

        // Stall and flush together: flush wins, count unchanged.
        drive(1, 1, 1, 1, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd10);
        tick();
        check_all("stall_flush", 0, 5'd0, 32'h0, 0, 64'd13);

        // Release: next capture resumes normally.
        drive(0, 0, 1, 1, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd10);
        tick();
        check_all("resume", 1, 5'd10, 32'h0000_0042, 1, 64'd14);

        // Reset beats stall: in-flight instruction discarded.
        reset_n = 1'b0;
        drive(1, 0, 1, 1, 2'b00, 3'b000, 32'h0000_0033, 32'h0, 32'h0, 5'd11);
        tick();
        check_all("reset_stall", 0, 5'd0, 32'h0, 0, 64'd0);
        reset_n = 1'b1;

        // Counter wrap on the 4-bit instance: 15 valid captures then one more.
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 1, 1, 2'b00, 3'b000, 32'(k), 32'h0, 32'h0, 5'd2);
            tick();
        end
        check("pre_wrap.instret4", 64'(instret_w2), 64'd15);
        check("pre_wrap.instret", instret_w, 64'd15);
        drive(0, 0, 1, 1, 2'b00, 3'b000, 32'h0000_0010, 32'h0, 32'h0, 5'd2);
        tick();
        check("wrap.instret4", 64'(instret_w2), 64'd0);
        check("wrap.instret", instret_w, 64'd16);
        check("wrap.result", 64'(result_w), 64'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
